// File: rtl/rca_nibble_sequencer.sv
// rca_nibble_sequencer: computes WIDTH-bit sums by stepping one 4-bit
// ripple-carry adder across WIDTH/4 nibbles, LSB first, with a registered
// carry between nibbles. Optional subtraction is built when RCA_SEQ_SUB_EN
// is defined; otherwise SUB is ignored.

// 4-bit ripple-carry adder shared by every nibble step.
module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    // Ripple the carry through four full adders.
    always_comb begin
        logic c;
        c = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module rca_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             READY,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             accept;
    logic [3:0]       a_nib, b_nib, add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    assign accept = START && (state_q == S_IDLE || state_q == S_DONE);

`ifdef RCA_SEQ_SUB_EN
    // Subtraction stores the inverted B and forces carry-in to 1 (two's complement).
    always_comb begin
        b_load     = SUB ? ~B : B;
        carry_load = SUB ? 1'b1 : CIN;
    end
`else
    logic unused_sub;
    assign unused_sub = SUB;

    // Addition only: operands pass straight through.
    always_comb begin
        b_load     = B;
        carry_load = CIN;
    end
`endif

    // Select the operand nibbles addressed by the current index.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IDX_W'(n)) begin
                a_nib = a_q[4*n +: 4];
                b_nib = b_q[4*n +: 4];
            end
        end
    end

    rca4 u_rca4 (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (idx_q == LAST_IDX) state_d = S_DONE;
            S_DONE:  state_d = accept ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        READY = 1'b0;
        BUSY  = 1'b0;
        DONE  = 1'b0;
        case (state_q)
            S_IDLE:  READY = 1'b1;
            S_RUN:   BUSY  = 1'b1;
            S_DONE:  begin READY = 1'b1; DONE = 1'b1; end
            default: READY = 1'b0;
        endcase
    end

    // Datapath next values: capture on accept, write one result nibble per RUN cycle.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (accept) begin
            a_d     = A;
            b_d     = b_load;
            carry_d = carry_load;
            idx_d   = '0;
        end else if (state_q == S_RUN) begin
            for (int n = 0; n < NIBBLES; n++) begin
                if (idx_q == IDX_W'(n)) sum_d[4*n +: 4] = add_sum;
            end
            carry_d = add_cout;
            if (idx_q == LAST_IDX) begin
                cout_d = add_cout;
                idx_d  = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Control and result registers; these have defined reset values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Operand registers are only read after a capture, so they need no reset.
    always_ff @(posedge CLK) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign SUM  = sum_q;
    assign COUT = cout_q;
endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Directed bench for rca_nibble_sequencer: WIDTH=16 main instance plus a
// WIDTH=4 instance. Subtraction expectations follow RCA_SEQ_SUB_EN.
module tb_rca_nibble_sequencer;
    logic        CLK = 1'b0;
    logic        RST;
    logic        START, CIN, SUB;
    logic [15:0] A, B;
    logic        READY, BUSY, DONE, COUT;
    logic [15:0] SUM;

    logic        START4, CIN4, SUB4;
    logic [3:0]  A4, B4;
    logic        READY4, BUSY4, DONE4, COUT4;
    logic [3:0]  SUM4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    rca_nibble_sequencer #(.WIDTH(16)) dut (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .CIN(CIN), .SUB(SUB),
        .READY(READY), .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .COUT(COUT)
    );

    rca_nibble_sequencer #(.WIDTH(4)) dut4 (
        .CLK(CLK), .RST(RST), .START(START4), .A(A4), .B(B4), .CIN(CIN4), .SUB(SUB4),
        .READY(READY4), .BUSY(BUSY4), .DONE(DONE4), .SUM(SUM4), .COUT(COUT4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one operation, scramble the inputs after acceptance, wait for DONE.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input logic [15:0] es, input logic ec,
                         input string tag);
        int lat;
        int busy_cycles;
        check({tag, ".ready_pre"}, 32'(READY), 32'd1);
        A = a; B = b; CIN = cin; SUB = sub; START = 1'b1;
        tick();
        START = 1'b0;
        A = 16'($urandom); B = 16'($urandom); CIN = ~cin; SUB = ~sub;
        lat = 0;
        busy_cycles = 0;
        while (!DONE && lat < 20) begin
            if (BUSY) busy_cycles++;
            tick();
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'd4);
        check({tag, ".busy_cycles"}, 32'(busy_cycles), 32'd4);
        check({tag, ".sum"}, 32'(SUM), 32'(es));
        check({tag, ".cout"}, 32'(COUT), 32'(ec));
        tick();
        check({tag, ".done_pulse"}, 32'(DONE), 32'd0);
        check({tag, ".ready_post"}, 32'(READY), 32'd1);
    endtask

    initial begin
        int lat;
        int dones;
        RST = 1'b1; START = 1'b0; A = '0; B = '0; CIN = 1'b0; SUB = 1'b0;
        START4 = 1'b0; A4 = '0; B4 = '0; CIN4 = 1'b0; SUB4 = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        check("rst.ready", 32'(READY), 32'd1);
        check("rst.busy",  32'(BUSY),  32'd0);
        check("rst.done",  32'(DONE),  32'd0);
        check("rst.sum",   32'(SUM),   32'd0);
        check("rst.cout",  32'(COUT),  32'd0);

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, "add_basic");
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, "ripple_all");
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, "msb_carry");
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, "mid_carry");

        // Result holds through idle cycles.
        tick(); tick(); tick();
        check("hold.sum",  32'(SUM),  32'h1000);
        check("hold.cout", 32'(COUT), 32'd0);

`ifdef RCA_SEQ_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, "sub_borrow");
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, "sub_noborrow");
`else
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, "sub_ignored");
        do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h000D, 1'b0, "sub_ignored_cin");
`endif

        // START during RUN is ignored; START in the DONE cycle starts the next op.
        A = 16'h00FF; B = 16'h0001; CIN = 1'b0; SUB = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        A = 16'hAAAA; B = 16'h5555;
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        lat = 2;
        while (!DONE && lat < 20) begin
            tick();
            lat++;
        end
        check("b2b.first_latency", 32'(lat), 32'd4);
        check("b2b.first_sum", 32'(SUM), 32'h0100);
        A = 16'h0001; B = 16'h0001; START = 1'b1;
        tick();
        START = 1'b0;
        check("b2b.busy_after_accept", 32'(BUSY), 32'd1);
        lat = 1;
        while (!DONE && lat < 20) begin
            tick();
            lat++;
        end
        check("b2b.spacing", 32'(lat), 32'd5);
        check("b2b.second_sum", 32'(SUM), 32'h0002);
        check("b2b.second_cout", 32'(COUT), 32'd0);
        tick();

        // Mid-operation reset in the second RUN cycle.
        A = 16'h1111; B = 16'h2222; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        check("abort.busy_before", 32'(BUSY), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort.ready", 32'(READY), 32'd1);
        check("abort.busy",  32'(BUSY),  32'd0);
        check("abort.sum",   32'(SUM),   32'd0);
        check("abort.cout",  32'(COUT),  32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (DONE) dones++;
            tick();
        end
        check("abort.no_done", 32'(dones), 32'd0);

        // WIDTH=4 instance: single RUN cycle.
        A4 = 4'h9; B4 = 4'h8; CIN4 = 1'b0; START4 = 1'b1;
        tick();
        START4 = 1'b0; A4 = 4'h0; B4 = 4'h0;
        check("w4.busy", 32'(BUSY4), 32'd1);
        tick();
        check("w4.done", 32'(DONE4), 32'd1);
        check("w4.sum",  32'(SUM4),  32'h1);
        check("w4.cout", 32'(COUT4), 32'd1);
        tick();
        check("w4.done_pulse", 32'(DONE4), 32'd0);
        A4 = 4'h7; B4 = 4'h8; CIN4 = 1'b1; START4 = 1'b1;
        tick();
        START4 = 1'b0;
        tick();
        check("w4b.sum",  32'(SUM4),  32'h0);
        check("w4b.cout", 32'(COUT4), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
